// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch front end: owns the fetch PC, issues sequential imem reads
// under a credit limit and queues returned words with their PC+4 for IF/ID.
module instr_prefetch_buffer #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                     clk,
   input  logic                     rst_n,
   output logic                     imem_req,
   output logic [31:0]              imem_addr,
   input  logic [31:0]              imem_data,
   input  logic                     redirect,
   input  logic [31:0]              redirect_pc,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_instr,
   output logic [31:0]              out_pc4,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned OW = PW + 1;
   localparam int unsigned CW = OW + 1;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc4;
   } entry_t;

   entry_t        fifo_q [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [OW-1:0] count;
   logic [31:0]   fetch_pc;
   logic [31:0]   inflight_pc;
   logic          inflight;
   logic          push;
   logic          pop;

   assign imem_addr = fetch_pc;
   assign occupancy = count;

   // Credit check counts the in-flight read as already occupying a slot.
   always_comb begin
      imem_req  = 1'b0;
      out_valid = 1'b0;
      out_instr = 32'h0;
      out_pc4   = 32'h0;
      push      = 1'b0;
      pop       = 1'b0;
      imem_req  = rst_n & ~redirect &
                  ((CW'(count) + CW'(inflight)) < CW'(DEPTH));
      out_valid = (count != '0) & ~redirect;
      if (count != '0) begin
         out_instr = fifo_q[rd_ptr].instr;
         out_pc4   = fifo_q[rd_ptr].pc4;
      end
      push = inflight & ~redirect;
      pop  = out_valid & out_ready;
   end

   // Redirect wins over everything: flushes queue and drops any returning word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc    <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= 32'h0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            fifo_q[i] <= '0;
         end
      end else if (redirect) begin
         fetch_pc <= {redirect_pc[31:2], 2'b00};
         inflight <= 1'b0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else begin
         if (push) begin
            fifo_q[wr_ptr] <= '{instr: imem_data, pc4: inflight_pc + 32'd4};
            wr_ptr         <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         count    <= count + OW'(push) - OW'(pop);
         inflight <= imem_req;
         if (imem_req) begin
            inflight_pc <= fetch_pc;
            fetch_pc    <= fetch_pc + 32'd4;
         end
      end
   end

endmodule
